esm_issue_scheduler: RTL and testbench

//  - Sequencer for the ESM dependency analyser (IRT/IDT instruction buffer of BS slots).
//  - Allocates a free slot per incoming instruction and drives the analyser's write index/enable.
//  - Picks one dependency-free waiting slot per cycle and issues it over a valid/ready handshake.
//  - Frees a slot on completion and pulses a clear request so the analyser drops that slot's dependencies.

---
 rtl/esm_pkg.sv | 31 +++
 rtl/esm_rr_picker.sv | 30 +++
 rtl/esm_issue_scheduler.sv | 144 ++++++++++++++
 tb/tb_esm_issue_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esm_pkg.sv
// Shared types and helpers for the ESM issue scheduler.
// Slot state encoding, index/counter width helpers and the lowest-set-bit finder.
package esm_pkg;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'b00,
    SLOT_WAITING = 2'b01,
    SLOT_ISSUED  = 2'b10
  } slot_state_t;

  // Widest buffer the lowest-set-bit helper can scan.
  localparam int ESM_MAX_BS = 64;

  function automatic int idx_w(input int bs);
    return (bs > 1) ? $clog2(bs) : 1;
  endfunction

  function automatic int cnt_w(input int bs);
    return $clog2(bs) + 1;
  endfunction

  function automatic int lowest_set(input logic [ESM_MAX_BS-1:0] v);
    int r;
    r = 0;
    for (int i = ESM_MAX_BS - 1; i >= 0; i--) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/esm_rr_picker.sv
// Combinational rotating-priority picker: grants the first set candidate at or after i_ptr.
// With i_ptr tied to zero it degenerates to lowest-index-wins.
module esm_rr_picker
  import esm_pkg::*;
#(
  parameter  int BS    = 16,
  localparam int IDX_W = idx_w(BS)
) (
  input  logic [BS-1:0]    i_cand,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_grant_valid,
  output logic [IDX_W-1:0] o_grant_index
);

  // Scan offsets from far to near so the smallest offset from i_ptr is written last.
  always_comb begin
    logic [IDX_W-1:0] w_idx;
    w_idx         = '0;
    o_grant_valid = 1'b0;
    o_grant_index = '0;
    for (int k = BS - 1; k >= 0; k--) begin
      w_idx = i_ptr + IDX_W'(k);
      if (i_cand[w_idx]) begin
        o_grant_valid = 1'b1;
        o_grant_index = w_idx;
      end
    end
  end

endmodule

// File: rtl/esm_issue_scheduler.sv
// Issue sequencer for the ESM dependency analyser: slot allocation, dependency-free pick, completion.
// Build option ESM_ROUND_ROBIN_EN selects rotating pick priority; default is lowest slot first.
module esm_issue_scheduler
  import esm_pkg::*;
#(
  parameter  int BS    = 16,
  localparam int IDX_W = idx_w(BS),
  localparam int CNT_W = cnt_w(BS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  output logic                 o_alloc_we,
  output logic [IDX_W-1:0]     o_alloc_index,
  input  logic [0:BS-1]        i_indep,
  output logic                 o_issue_valid,
  input  logic                 i_issue_ready,
  output logic [IDX_W-1:0]     o_issue_index,
  input  logic                 i_done_valid,
  input  logic [IDX_W-1:0]     i_done_index,
  output logic                 o_clr_valid,
  output logic [IDX_W-1:0]     o_clr_index,
  output logic [CNT_W-1:0]     o_occupancy,
  output logic                 o_err_done,
  output logic [BS-1:0][1:0]   o_dbg_state
);

  slot_state_t      r_state     [BS];
  slot_state_t      w_state_nxt [BS];
  logic [BS-1:0]    w_free;
  logic [BS-1:0]    w_waiting;
  logic [BS-1:0]    w_presented;
  logic [BS-1:0]    w_cand;
  logic             w_alloc;
  logic             w_hs;
  logic             w_load;
  logic             w_done_ok;
  logic             w_done_bad;
  logic             w_grant_valid;
  logic [IDX_W-1:0] w_grant_index;
  logic [IDX_W-1:0] w_ptr;
  logic             r_issue_valid;
  logic [IDX_W-1:0] r_issue_index;
  logic             r_clr_valid;
  logic [IDX_W-1:0] r_clr_index;
  logic [CNT_W-1:0] r_occ;
  logic             r_err;

  // Slot-state decode; the slot on the issue port is kept out of the candidate set.
  always_comb begin
    for (int i = 0; i < BS; i++) begin
      w_free[i]      = (r_state[i] == SLOT_FREE);
      w_waiting[i]   = (r_state[i] == SLOT_WAITING);
      w_presented[i] = r_issue_valid && (r_issue_index == IDX_W'(i));
      w_cand[i]      = i_indep[i] & w_waiting[i] & ~w_presented[i];
      o_dbg_state[i] = r_state[i];
    end
  end

  assign o_in_ready    = |w_free;
  assign w_alloc       = i_in_valid & o_in_ready;
  assign o_alloc_we    = w_alloc;
  assign o_alloc_index = IDX_W'(lowest_set(ESM_MAX_BS'(w_free)));

  // Issue port: o_issue_valid/o_issue_index stay put until i_issue_ready is seen high
  // with o_issue_valid; that cycle is the handshake and the slot becomes ISSUED.
  assign w_hs       = r_issue_valid & i_issue_ready;
  assign w_load     = ~r_issue_valid | w_hs;
  assign w_done_ok  = i_done_valid && (r_state[i_done_index] == SLOT_ISSUED);
  assign w_done_bad = i_done_valid & ~w_done_ok;

  // Per-slot next state; later writes win, giving done > issue > alloc.
  always_comb begin
    for (int i = 0; i < BS; i++) begin
      w_state_nxt[i] = r_state[i];
      if (w_alloc && (o_alloc_index == IDX_W'(i))) w_state_nxt[i] = SLOT_WAITING;
      if (w_hs && (r_issue_index == IDX_W'(i)))    w_state_nxt[i] = SLOT_ISSUED;
      if (w_done_ok && (i_done_index == IDX_W'(i))) w_state_nxt[i] = SLOT_FREE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BS; i++) r_state[i] <= SLOT_FREE;
    end else begin
      for (int i = 0; i < BS; i++) r_state[i] <= w_state_nxt[i];
    end
  end

`ifdef ESM_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_rr_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_rr_ptr <= '0;
    else if (w_hs) r_rr_ptr <= r_issue_index + IDX_W'(1);
  end

  assign w_ptr = r_rr_ptr;
`else
  assign w_ptr = '0;
`endif

  esm_rr_picker #(.BS(BS)) u_picker (
    .i_cand        (w_cand),
    .i_ptr         (w_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_index (w_grant_index)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_issue_valid <= 1'b0;
      r_issue_index <= '0;
    end else if (w_load) begin
      r_issue_valid <= w_grant_valid;
      if (w_grant_valid) r_issue_index <= w_grant_index;
    end
  end

  // Occupancy cannot wrap: alloc needs a FREE slot and a valid done needs an ISSUED one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clr_valid <= 1'b0;
      r_clr_index <= '0;
      r_occ       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_clr_valid <= w_done_ok;
      if (w_done_ok) r_clr_index <= i_done_index;
      if (w_alloc && !w_done_ok)      r_occ <= r_occ + CNT_W'(1);
      else if (!w_alloc && w_done_ok) r_occ <= r_occ - CNT_W'(1);
      if (w_done_bad) r_err <= 1'b1;
    end
  end

  assign o_issue_valid = r_issue_valid;
  assign o_issue_index = r_issue_index;
  assign o_clr_valid   = r_clr_valid;
  assign o_clr_index   = r_clr_index;
  assign o_occupancy   = r_occ;
  assign o_err_done    = r_err;

endmodule

// File: tb/tb_esm_issue_scheduler.sv
// Bench for esm_issue_scheduler: directed scenarios plus randomized traffic against a slot-level model.
// Compile with ESM_ROUND_ROBIN_EN defined to exercise the rotating-priority build.
module tb_esm_issue_scheduler;
  localparam int BS      = 16;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 5;
  localparam int FREE    = 0;
  localparam int WAITING = 1;
  localparam int ISSUED  = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic               alloc_we;
  logic [IDX_W-1:0]   alloc_index;
  logic [0:BS-1]      indep;
  logic               issue_valid;
  logic               issue_ready;
  logic [IDX_W-1:0]   issue_index;
  logic               done_valid;
  logic [IDX_W-1:0]   done_index;
  logic               clr_valid;
  logic [IDX_W-1:0]   clr_index;
  logic [CNT_W-1:0]   occupancy;
  logic               err_done;
  logic [BS-1:0][1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: per-slot status plus what the issue/clear ports should show.
  int m_st [BS];
  bit m_iv;
  int m_ii;
  bit m_cv;
  int m_ci;
  int m_occ;
  bit m_err;
`ifdef ESM_ROUND_ROBIN_EN
  int m_ptr;
`endif

  always #5 clk = ~clk;

  esm_issue_scheduler #(.BS(BS)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .o_alloc_we    (alloc_we),
    .o_alloc_index (alloc_index),
    .i_indep       (indep),
    .o_issue_valid (issue_valid),
    .i_issue_ready (issue_ready),
    .o_issue_index (issue_index),
    .i_done_valid  (done_valid),
    .i_done_index  (done_index),
    .o_clr_valid   (clr_valid),
    .o_clr_index   (clr_index),
    .o_occupancy   (occupancy),
    .o_err_done    (err_done),
    .o_dbg_state   (dbg_state)
  );

  function automatic void m_reset();
    for (int i = 0; i < BS; i++) m_st[i] = FREE;
    m_iv = 0; m_ii = 0; m_cv = 0; m_ci = 0; m_occ = 0; m_err = 0;
`ifdef ESM_ROUND_ROBIN_EN
    m_ptr = 0;
`endif
  endfunction

  function automatic int m_lowest_free();
    for (int i = 0; i < BS; i++) if (m_st[i] == FREE) return i;
    return -1;
  endfunction

  function automatic int m_pick();
    int start;
    start = 0;
`ifdef ESM_ROUND_ROBIN_EN
    start = m_ptr;
`endif
    for (int k = 0; k < BS; k++) begin
      int s;
      s = (start + k) % BS;
      if (indep[s] && m_st[s] == WAITING && !(m_iv && s == m_ii)) return s;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_step();
    int af, p, old_ii, di;
    bit alloc, hs, dok;
    af     = m_lowest_free();
    alloc  = in_valid && (af >= 0);
    hs     = m_iv && issue_ready;
    di     = int'(done_index);
    dok    = done_valid && (m_st[di] == ISSUED);
    old_ii = m_ii;
    if (done_valid && !dok) m_err = 1;
    if (!m_iv || hs) begin
      p    = m_pick();
      m_iv = (p >= 0);
      if (p >= 0) m_ii = p;
    end
    if (alloc) m_st[af] = WAITING;
    if (hs)    m_st[old_ii] = ISSUED;
    if (dok)   m_st[di] = FREE;
`ifdef ESM_ROUND_ROBIN_EN
    if (hs) m_ptr = (old_ii + 1) % BS;
`endif
    m_occ = m_occ + (alloc ? 1 : 0) - (dok ? 1 : 0);
    m_cv  = dok;
    if (dok) m_ci = di;
  endfunction

  task automatic drive(input int iv, input logic [0:BS-1] ind, input int ir, input int dv, input int di);
    in_valid    = (iv != 0);
    indep       = ind;
    issue_ready = (ir != 0);
    done_valid  = (dv != 0);
    done_index  = IDX_W'(di);
    #1;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic cycle(input int iv, input logic [0:BS-1] ind, input int ir, input int dv, input int di);
    drive(iv, ind, ir, dv, di);
    advance();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, '0, 0, 0, 0);
    m_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL rst_issue_valid: got %0b expected 0", issue_valid); else n_pass++;
    n_checks++; if (issue_index !== 4'd0) $display("FAIL rst_issue_index: got %0d expected 0", issue_index); else n_pass++;
    n_checks++; if (clr_valid !== 1'b0) $display("FAIL rst_clr_valid: got %0b expected 0", clr_valid); else n_pass++;
    n_checks++; if (clr_index !== 4'd0) $display("FAIL rst_clr_index: got %0d expected 0", clr_index); else n_pass++;
    n_checks++; if (occupancy !== 5'd0) $display("FAIL rst_occupancy: got %0d expected 0", occupancy); else n_pass++;
    n_checks++; if (err_done !== 1'b0) $display("FAIL rst_err_done: got %0b expected 0", err_done); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0b expected 1", in_ready); else n_pass++;
    n_checks++; if (alloc_index !== 4'd0) $display("FAIL rst_alloc_index: got %0d expected 0", alloc_index); else n_pass++;
  endtask

  task automatic test_alloc();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, '0, 0, 0, 0);
      n_checks++; if (alloc_index !== IDX_W'(k)) $display("FAIL alloc_index: got %0d expected %0d", alloc_index, k); else n_pass++;
      n_checks++; if (alloc_we !== 1'b1) $display("FAIL alloc_we: got %0b expected 1", alloc_we); else n_pass++;
      advance();
      n_checks++; if (issue_valid !== 1'b0) $display("FAIL alloc_no_issue: got %0b expected 0", issue_valid); else n_pass++;
    end
    n_checks++; if (occupancy !== 5'd3) $display("FAIL alloc_occupancy: got %0d expected 3", occupancy); else n_pass++;
    drive(0, '0, 0, 0, 0);
    n_checks++; if (alloc_we !== 1'b0) $display("FAIL alloc_we_idle: got %0b expected 0", alloc_we); else n_pass++;
    advance();
  endtask

  task automatic test_issue_hold();
    logic [0:BS-1] ind;
    do_reset();
    repeat (3) cycle(1, '0, 0, 0, 0);
    ind = '0; ind[1] = 1'b1;
    cycle(0, ind, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (issue_valid !== 1'b1) $display("FAIL hold_valid cyc %0d: got %0b expected 1", k, issue_valid); else n_pass++;
      n_checks++; if (issue_index !== 4'd1) $display("FAIL hold_index cyc %0d: got %0d expected 1", k, issue_index); else n_pass++;
      cycle(0, ind, 0, 0, 0);
    end
    cycle(0, ind, 1, 0, 0);
    n_checks++; if (dbg_state[1] !== 2'(ISSUED)) $display("FAIL hold_slot1_issued: got %0d expected %0d", dbg_state[1], ISSUED); else n_pass++;
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL hold_no_repick: got %0b expected 0", issue_valid); else n_pass++;
    cycle(0, ind, 1, 0, 0);
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL hold_no_repick2: got %0b expected 0", issue_valid); else n_pass++;
  endtask

  task automatic test_full_done();
    logic [0:BS-1] ind;
    do_reset();
    repeat (BS) cycle(1, '0, 0, 0, 0);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %0b expected 0", in_ready); else n_pass++;
    n_checks++; if (occupancy !== 5'd16) $display("FAIL full_occupancy: got %0d expected 16", occupancy); else n_pass++;
    drive(1, '0, 0, 0, 0);
    n_checks++; if (alloc_we !== 1'b0) $display("FAIL full_alloc_we: got %0b expected 0", alloc_we); else n_pass++;
    advance();
    ind = '0; ind[5] = 1'b1;
    cycle(0, ind, 0, 0, 0);
    n_checks++; if (issue_index !== 4'd5) $display("FAIL full_issue_index: got %0d expected 5", issue_index); else n_pass++;
    cycle(0, '0, 1, 0, 0);
    n_checks++; if (dbg_state[5] !== 2'(ISSUED)) $display("FAIL full_slot5_issued: got %0d expected %0d", dbg_state[5], ISSUED); else n_pass++;
    drive(1, '0, 0, 1, 5);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL done_cycle_in_ready: got %0b expected 0", in_ready); else n_pass++;
    advance();
    n_checks++; if (clr_valid !== 1'b1) $display("FAIL clr_valid: got %0b expected 1", clr_valid); else n_pass++;
    n_checks++; if (clr_index !== 4'd5) $display("FAIL clr_index: got %0d expected 5", clr_index); else n_pass++;
    n_checks++; if (occupancy !== 5'd15) $display("FAIL done_occupancy: got %0d expected 15", occupancy); else n_pass++;
    n_checks++; if (alloc_index !== 4'd5) $display("FAIL realloc_index: got %0d expected 5", alloc_index); else n_pass++;
    cycle(1, '0, 0, 0, 0);
    n_checks++; if (clr_valid !== 1'b0) $display("FAIL clr_pulse_end: got %0b expected 0", clr_valid); else n_pass++;
    n_checks++; if (dbg_state[5] !== 2'(WAITING)) $display("FAIL realloc_slot5: got %0d expected %0d", dbg_state[5], WAITING); else n_pass++;
  endtask

  task automatic test_fixed_pick();
    logic [0:BS-1] ind;
    do_reset();
    repeat (8) cycle(1, '0, 0, 0, 0);
    ind = '0; ind[3] = 1'b1; ind[7] = 1'b1;
    cycle(0, ind, 1, 0, 0);
    n_checks++; if (issue_valid !== 1'b1 || issue_index !== 4'd3) $display("FAIL pick_first: got v%0b/%0d expected v1/3", issue_valid, issue_index); else n_pass++;
    cycle(0, ind, 1, 0, 0);
    n_checks++; if (issue_valid !== 1'b1 || issue_index !== 4'd7) $display("FAIL pick_second: got v%0b/%0d expected v1/7", issue_valid, issue_index); else n_pass++;
    cycle(0, ind, 1, 0, 0);
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL pick_empty: got %0b expected 0", issue_valid); else n_pass++;
  endtask

`ifdef ESM_ROUND_ROBIN_EN
  task automatic test_rr_wrap();
    int seen;
    int di;
    bit dv;
    do_reset();
    repeat (BS) cycle(1, '0, 0, 0, 0);
    seen = 0;
    for (int c = 0; c < 40 && seen < 24; c++) begin
      dv = 0; di = 0;
      for (int s = BS - 1; s >= 0; s--) if (m_st[s] == ISSUED) begin dv = 1; di = s; end
      drive(1, '1, 1, dv, di);
      if (issue_valid === 1'b1) begin
        n_checks++;
        if (issue_index !== IDX_W'(seen % BS)) $display("FAIL rr_order #%0d: got %0d expected %0d", seen, issue_index, seen % BS);
        else n_pass++;
        seen++;
      end
      advance();
    end
    n_checks++; if (seen != 24) $display("FAIL rr_timeout: got %0d issues expected 24", seen); else n_pass++;
  endtask
`endif

  task automatic test_err();
    do_reset();
    repeat (3) cycle(1, '0, 0, 0, 0);
    cycle(0, '0, 0, 1, 2);
    n_checks++; if (err_done !== 1'b1) $display("FAIL err_set: got %0b expected 1", err_done); else n_pass++;
    n_checks++; if (dbg_state[2] !== 2'(WAITING)) $display("FAIL err_slot2: got %0d expected %0d", dbg_state[2], WAITING); else n_pass++;
    n_checks++; if (occupancy !== 5'd3) $display("FAIL err_occupancy: got %0d expected 3", occupancy); else n_pass++;
    n_checks++; if (clr_valid !== 1'b0) $display("FAIL err_no_clr: got %0b expected 0", clr_valid); else n_pass++;
    cycle(0, '0, 0, 0, 0);
    n_checks++; if (err_done !== 1'b1) $display("FAIL err_sticky: got %0b expected 1", err_done); else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [0:BS-1] ind;
    do_reset();
    repeat (3) cycle(1, '0, 0, 0, 0);
    ind = '0; ind[0] = 1'b1; ind[1] = 1'b1;
    cycle(0, ind, 0, 0, 0);
    cycle(0, ind, 1, 0, 0);
    n_checks++; if (issue_valid !== 1'b1 || issue_index !== 4'd1) $display("FAIL sim_setup: got v%0b/%0d expected v1/1", issue_valid, issue_index); else n_pass++;
    drive(1, ind, 1, 1, 0);
    n_checks++; if (alloc_we !== 1'b1 || alloc_index !== 4'd3) $display("FAIL sim_alloc: got we%0b/%0d expected we1/3", alloc_we, alloc_index); else n_pass++;
    advance();
    n_checks++; if (occupancy !== 5'd3) $display("FAIL sim_occupancy: got %0d expected 3", occupancy); else n_pass++;
    n_checks++; if (dbg_state[0] !== 2'(FREE)) $display("FAIL sim_slot0: got %0d expected %0d", dbg_state[0], FREE); else n_pass++;
    n_checks++; if (dbg_state[1] !== 2'(ISSUED)) $display("FAIL sim_slot1: got %0d expected %0d", dbg_state[1], ISSUED); else n_pass++;
    n_checks++; if (dbg_state[3] !== 2'(WAITING)) $display("FAIL sim_slot3: got %0d expected %0d", dbg_state[3], WAITING); else n_pass++;
    n_checks++; if (clr_valid !== 1'b1 || clr_index !== 4'd0) $display("FAIL sim_clr: got v%0b/%0d expected v1/0", clr_valid, clr_index); else n_pass++;
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL sim_no_issue: got %0b expected 0", issue_valid); else n_pass++;
  endtask

  task automatic test_random();
    int q[$];
    int di, dv;
    logic [0:BS-1] ind;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      q.delete();
      for (int s = 0; s < BS; s++) if (m_st[s] == ISSUED) q.push_back(s);
      dv = 0; di = 0;
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        dv = 1; di = q[$urandom_range(0, q.size() - 1)];
      end else if ($urandom_range(0, 19) == 0) begin
        dv = 1; di = $urandom_range(0, BS - 1);
      end
      ind = 16'($urandom());
      drive(($urandom_range(0, 2) != 0) ? 1 : 0, ind, ($urandom_range(0, 3) != 0) ? 1 : 0, dv, di);
      n_checks++; if (in_ready !== (m_lowest_free() >= 0)) $display("FAIL rnd_in_ready cyc %0d: got %0b expected %0b", c, in_ready, m_lowest_free() >= 0); else n_pass++;
      if (m_lowest_free() >= 0) begin
        n_checks++; if (alloc_index !== IDX_W'(m_lowest_free())) $display("FAIL rnd_alloc_index cyc %0d: got %0d expected %0d", c, alloc_index, m_lowest_free()); else n_pass++;
      end
      n_checks++; if (alloc_we !== (in_valid && m_lowest_free() >= 0)) $display("FAIL rnd_alloc_we cyc %0d: got %0b", c, alloc_we); else n_pass++;
      n_checks++; if (issue_valid !== m_iv) $display("FAIL rnd_issue_valid cyc %0d: got %0b expected %0b", c, issue_valid, m_iv); else n_pass++;
      if (m_iv) begin
        n_checks++; if (issue_index !== IDX_W'(m_ii)) $display("FAIL rnd_issue_index cyc %0d: got %0d expected %0d", c, issue_index, m_ii); else n_pass++;
      end
      n_checks++; if (clr_valid !== m_cv) $display("FAIL rnd_clr_valid cyc %0d: got %0b expected %0b", c, clr_valid, m_cv); else n_pass++;
      if (m_cv) begin
        n_checks++; if (clr_index !== IDX_W'(m_ci)) $display("FAIL rnd_clr_index cyc %0d: got %0d expected %0d", c, clr_index, m_ci); else n_pass++;
      end
      n_checks++; if (occupancy !== CNT_W'(m_occ)) $display("FAIL rnd_occupancy cyc %0d: got %0d expected %0d", c, occupancy, m_occ); else n_pass++;
      n_checks++; if (err_done !== m_err) $display("FAIL rnd_err_done cyc %0d: got %0b expected %0b", c, err_done, m_err); else n_pass++;
      for (int s = 0; s < BS; s++) begin
        n_checks++; if (dbg_state[s] !== 2'(m_st[s])) $display("FAIL rnd_slot%0d cyc %0d: got %0d expected %0d", s, c, dbg_state[s], m_st[s]); else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    logic [0:BS-1] ind;
    do_reset();
    repeat (2) cycle(1, '0, 0, 0, 0);
    ind = '0; ind[1] = 1'b1;
    cycle(0, ind, 0, 0, 0);
    cycle(0, ind, 0, 1, 0);
    n_checks++; if (issue_valid !== 1'b1 || issue_index !== 4'd1 || err_done !== 1'b1) $display("FAIL arst_setup: got v%0b/%0d err%0b expected v1/1 err1", issue_valid, issue_index, err_done); else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL arst_issue_valid: got %0b expected 0", issue_valid); else n_pass++;
    n_checks++; if (issue_index !== 4'd0) $display("FAIL arst_issue_index: got %0d expected 0", issue_index); else n_pass++;
    n_checks++; if (clr_valid !== 1'b0 || clr_index !== 4'd0) $display("FAIL arst_clr: got v%0b/%0d expected v0/0", clr_valid, clr_index); else n_pass++;
    n_checks++; if (occupancy !== 5'd0) $display("FAIL arst_occupancy: got %0d expected 0", occupancy); else n_pass++;
    n_checks++; if (err_done !== 1'b0) $display("FAIL arst_err_done: got %0b expected 0", err_done); else n_pass++;
    n_checks++; if (dbg_state !== '0) $display("FAIL arst_slots: got %h expected 0", dbg_state); else n_pass++;
    drive(0, '0, 0, 0, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, '0, 0, 0, 0);
    test_reset();
    test_alloc();
    test_issue_hold();
    test_full_done();
    test_fixed_pick();
`ifdef ESM_ROUND_ROBIN_EN
    test_rr_wrap();
`endif
    test_err();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
